sop_logic_pipe: RTL and testbench

//  Parametrised, run-time programmable sum-of-products engine: an N_IN-input, N_OUT-output PLA.
//  Has a 2-stage valid/ready evaluation pipeline and a config write port for both planes.

---
 rtl/sop_logic_pipe_if.sv | 32 +++
 rtl/sop_logic_pipe.sv | 175 +++++++++++++++++
 tb/tb_sop_logic_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sop_logic_pipe_if.sv
// Handshake bundle for sop_logic_pipe: evaluation stream in/out plus the plane config port.
// Widths are derived here so the engine and its neighbours always agree on CFG_W and A_W.
interface sop_logic_pipe_if #(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 4,
    parameter int N_OUT   = 2
);
    localparam int CFG_W = (2 * N_IN > N_TERMS) ? 2 * N_IN : N_TERMS;
    localparam int A_W   = $clog2(N_TERMS + N_OUT);

    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [A_W-1:0]    cfg_addr;
    logic [CFG_W-1:0]  cfg_data;
    logic              cfg_err;

    modport master (
        output in_valid, in_data, out_ready, cfg_valid, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, cfg_ready, cfg_err
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_valid, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, cfg_ready, cfg_err
    );
endinterface

// File: rtl/sop_logic_pipe.sv
// Run-time programmable PLA: AND plane -> S1 term register -> OR plane -> S2 output register.
// Config writes wait until both stages are empty, so every result sees a single plane set.
module sop_logic_pipe #(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 4,
    parameter int N_OUT   = 2,
    parameter int DEF_EQ  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    sop_logic_pipe_if.slave  bus
);
    localparam bit DEF_OK = (DEF_EQ == 1) && (N_IN == 4) && (N_OUT == 2) && (N_TERMS >= 4);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_WRITE} state_t;

    state_t state, state_next;

    logic [N_IN-1:0]    and_true [N_TERMS];
    logic [N_IN-1:0]    and_comp [N_TERMS];
    logic [N_TERMS-1:0] or_plane [N_OUT];

    logic               s1_valid;
    logic [N_TERMS-1:0] s1_terms;
    logic               s2_valid;
    logic [N_OUT-1:0]   s2_data;
    logic               cfg_err_q;

    logic [N_TERMS-1:0] terms;
    logic [N_OUT-1:0]   sop;
    logic               s1_load, s2_load, accept;
    logic               in_ready, cfg_ready, cfg_we, addr_ok;

    // Default equations, literals d=in[0] c=in[1] b=in[2] a=in[3]:
    // T0=d, T1=a&~b&c, T2=b&d, T3=a&~c&d; out0=T0|T1, out1=T2|T3.
    function automatic logic [N_IN-1:0] def_true(input int t);
        logic [3:0] m;
        case (t)
            0:       m = 4'b0001;
            1:       m = 4'b1010;
            2:       m = 4'b0101;
            3:       m = 4'b1001;
            default: m = 4'b0000;
        endcase
        return DEF_OK ? N_IN'(m) : '0;
    endfunction

    function automatic logic [N_IN-1:0] def_comp(input int t);
        logic [3:0] m;
        case (t)
            1:       m = 4'b0100;
            3:       m = 4'b0010;
            default: m = 4'b0000;
        endcase
        return DEF_OK ? N_IN'(m) : '0;
    endfunction

    function automatic logic [N_TERMS-1:0] def_or(input int o);
        logic [3:0] m;
        case (o)
            0:       m = 4'b0011;
            1:       m = 4'b1100;
            default: m = 4'b0000;
        endcase
        return DEF_OK ? N_TERMS'(m) : '0;
    endfunction

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        terms = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            terms[t] = &((~and_true[t] | bus.in_data) & (~and_comp[t] | ~bus.in_data));
        end
    end

    always_comb begin
        sop = '0;
        for (int o = 0; o < N_OUT; o++) begin
            sop[o] = |(or_plane[o] & s1_terms);
        end
    end

    // A stage may load when empty or when its current content leaves this same cycle.
    assign s2_load = ~s2_valid | bus.out_ready;
    assign s1_load = ~s1_valid | s2_load;
    assign accept  = bus.in_valid & in_ready;
    assign addr_ok = int'(bus.cfg_addr) < (N_TERMS + N_OUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Config wins over a simultaneous input vector: in_ready drops the moment cfg_valid is seen.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cfg_ready  = 1'b0;
        cfg_we     = 1'b0;
        case (state)
            ST_RUN: begin
                in_ready = s1_load & ~bus.cfg_valid;
                if (bus.cfg_valid) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.cfg_valid)             state_next = ST_RUN;
                else if (!s1_valid && !s2_valid) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                cfg_ready  = bus.cfg_valid;
                cfg_we     = bus.cfg_valid;
                state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_terms <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) s1_terms <= terms;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= sop;
            end
        end
    end

    // NOTE: the planes are plain flops with reset values, not a RAM: the engine must evaluate
    // the default equations straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < N_TERMS; t++) begin
                and_true[t] <= def_true(t);
                and_comp[t] <= def_comp(t);
            end
            for (int o = 0; o < N_OUT; o++) begin
                or_plane[o] <= def_or(o);
            end
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we & ~addr_ok;
            if (cfg_we) begin
                for (int t = 0; t < N_TERMS; t++) begin
                    if (int'(bus.cfg_addr) == t) begin
                        and_true[t] <= bus.cfg_data[N_IN-1:0];
                        and_comp[t] <= bus.cfg_data[2*N_IN-1:N_IN];
                    end
                end
                for (int o = 0; o < N_OUT; o++) begin
                    if (int'(bus.cfg_addr) == N_TERMS + o) begin
                        or_plane[o] <= bus.cfg_data[N_TERMS-1:0];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.cfg_ready = cfg_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_sop_logic_pipe.sv
// Bench for sop_logic_pipe: truth-table stream, random streams against a plane model,
// backpressure, config ordering, out-of-range writes and mid-stream reset.
module tb_sop_logic_pipe;
    logic clk;
    logic reset_n;

    sop_logic_pipe_if #(.N_IN(4), .N_TERMS(4), .N_OUT(2)) bus ();

    sop_logic_pipe #(.N_IN(4), .N_TERMS(4), .N_OUT(2), .DEF_EQ(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] vin;
        logic [1:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] vin;
        logic [1:0] exp;
        bit         lat;
        int         cyc;
    } sb_t;

    // Default equations evaluated by hand: {b&d | a&~c&d, d | a&~b&c}
    vec_t tbl [16] = '{
        '{4'd0,  2'b00}, '{4'd1,  2'b01}, '{4'd2,  2'b00}, '{4'd3,  2'b01},
        '{4'd4,  2'b00}, '{4'd5,  2'b11}, '{4'd6,  2'b00}, '{4'd7,  2'b11},
        '{4'd8,  2'b00}, '{4'd9,  2'b11}, '{4'd10, 2'b01}, '{4'd11, 2'b01},
        '{4'd12, 2'b00}, '{4'd13, 2'b11}, '{4'd14, 2'b00}, '{4'd15, 2'b11}
    };

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    sb_t        sb [$];
    logic [7:0] m_and [4];
    logic [3:0] m_or [2];
    bit         tbl_mode = 0;
    logic [1:0] tbl_exp = '0;
    logic [1:0] last_out = '0;
    int         last_acc_cyc = 0;
    int         last_cfg_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_and = '{8'h01, 8'h4A, 8'h05, 8'h29};
        m_or  = '{4'h3, 4'hC};
    endtask

    // A term fires when every literal it names is satisfied; an output ORs its selected terms.
    function automatic logic [1:0] model_eval(input logic [3:0] v);
        logic [1:0] r;
        bit hit;
        r = '0;
        for (int o = 0; o < 2; o++) begin
            for (int t = 0; t < 4; t++) begin
                if (m_or[o][t]) begin
                    hit = 1;
                    for (int i = 0; i < 4; i++) begin
                        if (m_and[t][i] && !v[i]) hit = 0;
                        if (m_and[t][4+i] && v[i]) hit = 0;
                    end
                    if (hit) r[o] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Monitor: samples mid-cycle, what it sees is what the next rising edge acts on.
    initial begin
        bit         prev_stall;
        logic [1:0] prev_data;
        sb_t        e;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, prev_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_count", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", bus.out_data, e.exp);
                        if (e.lat) check("latency", cyc - e.cyc, 2);
                    end
                    last_out = bus.out_data;
                end
                if (bus.in_valid && bus.in_ready) begin
                    e.vin = bus.in_data;
                    e.exp = tbl_mode ? tbl_exp : model_eval(bus.in_data);
                    e.lat = tbl_mode;
                    e.cyc = cyc;
                    sb.push_back(e);
                    last_acc_cyc = cyc;
                end
                if (bus.cfg_valid && bus.cfg_ready) last_cfg_cyc = cyc;
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic drain();
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        while ((sb.size() != 0 || bus.out_valid) && k < 60) begin
            step();
            k++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic run_stream(input int n, input bit use_tbl, input int stall_at, input int stall_len,
                              input bit rnd_ready, output int first_acc, output int last_acc);
        int         idx;
        int         k;
        bit         stalled;
        logic [3:0] v;
        idx = 0;
        k = 0;
        first_acc = 0;
        last_acc = 0;
        v = use_tbl ? tbl[0].vin : 4'($urandom);
        while (idx < n && k < 400) begin
            stalled = (k >= stall_at) && (k < stall_at + stall_len);
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : !stalled;
            bus.in_valid  = 1'b1;
            bus.in_data   = v;
            tbl_mode      = use_tbl;
            tbl_exp       = use_tbl ? tbl[idx].exp : 2'b00;
            @(negedge clk);
            if (stall_len > 0 && k == stall_at + stall_len - 1) begin
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_buffered", sb.size(), 2);
            end
            if (bus.in_ready) begin
                if (idx == 0) first_acc = cyc;
                last_acc = cyc;
                idx++;
                if (idx < n) v = use_tbl ? tbl[idx].vin : 4'($urandom);
            end
            step();
            k++;
        end
        check("stream_accepted", idx, n);
        bus.in_valid = 1'b0;
        tbl_mode = 0;
        drain();
    endtask

    task automatic push(input logic [3:0] v);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tbl_mode     = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        bit ok;
        ok = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_data  = d;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = bus.cfg_ready;
            if (ok) begin
                check("cfg_drained", sb.size(), 0);
                check("cfg_drained_valid", bus.out_valid, 0);
                check("cfg_err_pre", bus.cfg_err, 0);
            end
            step();
        end
        bus.cfg_valid = 1'b0;
        check("cfg_accepted", ok, 1);
        if (ok) begin
            if (a < 3'd4)      m_and[a[1:0]] = d;
            else if (a < 3'd6) m_or[a[0]]    = d[3:0];
        end
        @(negedge clk);
        check("cfg_err", bus.cfg_err, (a >= 3'd6) ? 1 : 0);
        step();
    endtask

    initial begin
        int fa, la;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Default truth table, back-to-back
        run_stream(16, 1, 0, 0, 0, fa, la);
        check("throughput", la - fa, 15);

        // Backpressure mid-stream
        run_stream(16, 0, 6, 5, 0, fa, la);

        // Write while pipe is full: old results leave before the write
        bus.out_ready = 1'b0;
        push(4'b1010);
        push(4'b0101);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_data  = 8'h01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_cfg_ready", bus.cfg_ready, 0);
            check("full_in_ready", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        cfg_write(3'd0, 8'h01);
        cfg_write(3'd4, 8'h01);
        push(4'b0001);
        drain();
        check("new_eq_0001", last_out[0], 1);
        push(4'b1110);
        drain();
        check("new_eq_1110", last_out[0], 0);

        // Simultaneous config and input: vector waits and sees the new planes
        fork
            cfg_write(3'd5, 8'h01);
            push(4'b0001);
        join
        drain();
        check("simul_result", last_out, 2'b11);
        check("simul_order", (last_acc_cyc > last_cfg_cyc) ? 1 : 0, 1);

        // Out-of-range address: error pulse, planes untouched
        cfg_write(3'd6, 8'hFF);
        @(negedge clk);
        check("cfg_err_one_cycle", bus.cfg_err, 0);
        step();
        run_stream(20, 0, 0, 0, 1, fa, la);

        // Random reprogramming, with bits above the row width set at random
        for (int r = 0; r < 5; r++) begin
            cfg_write(3'($urandom_range(0, 7)), 8'($urandom));
            run_stream(24, 0, 0, 0, 1, fa, la);
        end

        // Reset mid-stream after reprogramming
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = 4'($urandom);
            step();
        end
        #2;
        reset_n = 1'b0;
        sb.delete();
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        model_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("midrst_hold_valid", bus.out_valid, 0);
            step();
        end
        reset_n = 1'b1;
        step();
        run_stream(16, 1, 0, 0, 0, fa, la);
        run_stream(20, 0, 0, 0, 1, fa, la);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
